// File: rtl/bin2dec_pkg.sv
// Shared types and constants for the binary-to-decimal digit serializer.
//   state_t     : top-level FSM states
//   ASCII_*     : byte codes used when ASCII output is enabled
//   RAW_MINUS   : sign marker used in raw (nibble) output mode
//   min_digits  : decimal digits needed to hold any unsigned w-bit value
package bin2dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] RAW_MINUS   = 8'h0F;

    // Digit count of 2^w-1; evaluated at elaboration only.
    function automatic int min_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                n++;
                v = v / 10;
            end
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/bin2dec_stream_bcd_dabble_core.sv
// Iterative shift-add-3 (double dabble) converter.
//   clk, rst : clock, synchronous active-low reset
//   start    : load mag and clear the BCD accumulator
//   mag      : unsigned value to convert
//   done     : high during the cycle whose clock edge performs the final shift
//   bcd      : packed BCD result, digit 0 in bcd[3:0]; valid once done has been seen
module bcd_dabble_core
    import bin2dec_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       mag,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]       sh;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] adj;

    // Pre-shift correction: any nibble >= 5 would overflow past 9 after doubling.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcd <= '0;
            sh  <= '0;
            cnt <= '0;
        end else if (start) begin
            bcd <= '0;
            sh  <= mag;
            cnt <= CNT_W'(DATA_W);
        end else if (cnt != '0) begin
            {bcd, sh} <= {adj[4*NUM_DIGITS-2:0], sh, 1'b0};
            cnt       <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/bin2dec_stream.sv
// Binary-to-decimal digit serializer on a valid/ready byte stream.
//   clk, rst   : clock, synchronous active-low reset
//   in_valid   : in_data valid (source holds it until in_ready)
//   in_ready   : high only while idle
//   in_data    : value to convert (two's complement when SIGNED_EN)
//   out_valid  : out_data/out_last valid
//   out_ready  : sink accepts the current byte
//   out_data   : sign byte or decimal digit, MS digit first, leading zeros dropped
//   out_last   : marks the least significant digit byte
//   busy       : converting or emitting
module bin2dec_stream
    import bin2dec_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3,
    parameter bit ASCII_EN   = 1'b1,
    parameter bit SIGNED_EN  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (DATA_W < 4 || DATA_W > 32) begin : g_bad_width
        $error("bin2dec_stream: DATA_W must be in 4..32");
    end
    if (NUM_DIGITS < min_digits(DATA_W)) begin : g_bad_digits
        $error("bin2dec_stream: NUM_DIGITS too small for DATA_W");
    end

    state_t state, state_nxt;

    logic                           accept;
    logic                           xfer;
    logic                           neg_in;
    logic [DATA_W-1:0]              mag_in;
    logic                           neg;
    logic                           conv_done;
    logic [4*NUM_DIGITS-1:0]        bcd;
    logic [NUM_DIGITS-1:0][3:0]     dig;
    logic [IDX_W-1:0]               lead;
    logic [IDX_W-1:0]               idx;
    logic [7:0]                     sign_byte;

    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign sign_byte = ASCII_EN ? ASCII_MINUS : RAW_MINUS;

    // Negating the most negative value wraps to 2^(DATA_W-1), which is the
    // correct magnitude when read as unsigned.
    assign neg_in = SIGNED_EN & in_data[DATA_W-1];
    assign mag_in = neg_in ? (~in_data + DATA_W'(1)) : in_data;

    bcd_dabble_core #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .mag   (mag_in),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign dig = bcd;

    // Most significant nonzero digit; stays 0 for a zero value so one '0' is sent.
    always_comb begin
        lead = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig[i] != 4'd0)
                lead = IDX_W'(i);
        end
    end

    function automatic logic [7:0] fmt(input logic [3:0] d);
        return ASCII_EN ? (ASCII_ZERO + {4'h0, d}) : {4'h0, d};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)          state_nxt = CONV;
            CONV:    if (conv_done)       state_nxt = EMIT;
            EMIT:    if (xfer && out_last) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Output byte register. The first EMIT cycle loads the leading byte; each
    // handshake afterwards loads the next one, so a stalled byte never changes.
    // idx always names the next digit still to be sent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            neg       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            idx       <= '0;
        end else begin
            if (accept)
                neg <= neg_in;
            if (state == EMIT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    if (neg) begin
                        out_data <= sign_byte;
                        out_last <= 1'b0;
                        idx      <= lead;
                    end else begin
                        out_data <= fmt(dig[lead]);
                        out_last <= (lead == '0);
                        idx      <= lead - IDX_W'(1);
                    end
                end else if (xfer) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                    end else begin
                        out_data <= fmt(dig[idx]);
                        out_last <= (idx == '0);
                        idx      <= idx - IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2dec_stream.sv
// Bench for bin2dec_stream: three instances (8-bit ASCII unsigned, 8-bit
// ASCII signed, 16-bit raw unsigned), each driven one result at a time and
// checked against decimal strings produced with $sformatf.
module tb_bin2dec_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv   [3];
    logic       irdy [3];
    logic       ov   [3];
    logic       ordy [3];
    logic       ol   [3];
    logic       bsy  [3];
    logic [7:0] od   [3];
    logic [7:0] di0, di1;
    logic [15:0] di2;

    int checks   = 0;
    int failures = 0;
    int wid [3]  = '{8, 8, 16};

    logic [7:0] expq [$];

    bin2dec_stream #(.DATA_W(8), .NUM_DIGITS(3), .ASCII_EN(1'b1), .SIGNED_EN(1'b0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(di0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last(ol[0]), .busy(bsy[0]));

    bin2dec_stream #(.DATA_W(8), .NUM_DIGITS(3), .ASCII_EN(1'b1), .SIGNED_EN(1'b1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(di1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last(ol[1]), .busy(bsy[1]));

    bin2dec_stream #(.DATA_W(16), .NUM_DIGITS(5), .ASCII_EN(1'b0), .SIGNED_EN(1'b0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(di2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_last(ol[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the decimal text of the value, mapped to the output byte code.
    function automatic void build(input int d, input logic [31:0] val);
        longint     v;
        string      s;
        logic [7:0] c;
        case (d)
            0:       v = longint'(val[7:0]);
            1:       v = longint'($signed(val[7:0]));
            default: v = longint'(val[15:0]);
        endcase
        s = $sformatf("%0d", v);
        expq.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (d == 2)
                expq.push_back((c == 8'h2D) ? 8'h0F : (c - 8'h30));
            else
                expq.push_back(c);
        end
    endfunction

    task automatic set_di(input int d, input logic [31:0] val);
        case (d)
            0:       di0 = val[7:0];
            1:       di1 = val[7:0];
            default: di2 = val[15:0];
        endcase
    endtask

    // mode 0: ready always; 1: ready on alternate valid cycles; 2: random;
    // 3: 1,0,1,0 then 5 cycles low then high. abort_at>0 resets after that many bytes.
    task automatic run(input int d, input logic [31:0] val, input int mode, input int abort_at);
        int         k, nb, vc, exp_n;
        bit         seen, pv, pr, fin;
        logic [7:0] hd, e;
        logic       hl;
        build(d, val);
        exp_n = expq.size();
        @(negedge clk);
        set_di(d, val);
        iv[d] = 1'b1;
        k = 0;
        while (!irdy[d] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!irdy[d]) begin
            chk("accept_timeout", 32'(irdy[d]), 32'd1);
            iv[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        set_di(d, 32'($urandom));
        chk("busy_conv", 32'(bsy[d]), 32'd1);
        chk("in_ready_conv", 32'(irdy[d]), 32'd0);
        k = 0; nb = 0; vc = 0; seen = 0; pv = 0; pr = 0; fin = 0;
        hd = '0; hl = 1'b0;
        while (!fin && k < 300) begin
            if (ov[d]) begin
                if (!seen) begin
                    seen = 1;
                    chk("latency", 32'(k), 32'(wid[d] + 1));
                end
                if (pv && !pr) begin
                    chk("hold_data", 32'(od[d]), 32'(hd));
                    chk("hold_last", 32'(ol[d]), 32'(hl));
                end
                case (mode)
                    0:       ordy[d] = 1'b1;
                    1:       ordy[d] = (vc % 2 == 0);
                    2:       ordy[d] = 1'($urandom_range(0, 1));
                    default: ordy[d] = (vc < 4) ? (vc % 2 == 0) : (vc >= 9);
                endcase
                vc++;
                hd = od[d];
                hl = ol[d];
                if (ordy[d]) begin
                    if (expq.size() == 0) begin
                        chk("extra_byte", 32'(nb + 1), 32'(exp_n));
                    end else begin
                        e = expq.pop_front();
                        chk("data", 32'(od[d]), 32'(e));
                        chk("last", 32'(ol[d]), 32'(expq.size() == 0));
                    end
                    nb++;
                    if (ol[d]) fin = 1;
                end
            end else begin
                if (pv && !pr) chk("valid_drop", 32'(ov[d]), 32'd1);
                ordy[d] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            pv = ov[d];
            pr = ordy[d];
            @(posedge clk);
            @(negedge clk);
            k++;
            if (abort_at > 0 && nb == abort_at) begin
                ordy[d] = 1'b0;
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("rst_out_valid", 32'(ov[d]), 32'd0);
                chk("rst_out_data", 32'(od[d]), 32'd0);
                chk("rst_out_last", 32'(ol[d]), 32'd0);
                chk("rst_in_ready", 32'(irdy[d]), 32'd1);
                chk("rst_busy", 32'(bsy[d]), 32'd0);
                rst = 1'b1;
                return;
            end
        end
        ordy[d] = 1'b0;
        chk("emit_done", 32'(fin), 32'd1);
        chk("byte_count", 32'(nb), 32'(exp_n));
        chk("idle_in_ready", 32'(irdy[d]), 32'd1);
        chk("idle_busy", 32'(bsy[d]), 32'd0);
        chk("idle_out_valid", 32'(ov[d]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        rst = 1'b0;
        di0 = '0; di1 = '0; di2 = '0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_out_valid", 32'(ov[i]), 32'd0);
            chk("reset_out_data", 32'(od[i]), 32'd0);
            chk("reset_out_last", 32'(ol[i]), 32'd0);
            chk("reset_in_ready", 32'(irdy[i]), 32'd1);
            chk("reset_busy", 32'(bsy[i]), 32'd0);
        end
        rst = 1'b1;

        run(0, 255, 0, 0);
        run(0, 7, 0, 0);
        run(0, 0, 0, 0);
        run(1, 32'h80, 0, 0);
        run(1, 32'hFF, 0, 0);
        run(1, 32'h7F, 0, 0);
        run(1, 0, 0, 0);
        run(0, 128, 3, 0);
        run(0, 128, 1, 0);
        run(2, 65535, 0, 0);
        run(2, 1000, 0, 0);
        run(2, 0, 3, 0);
        run(0, 255, 0, 1);
        run(0, 42, 0, 0);

        for (int n = 0; n < 20; n++) begin
            r = $urandom;
            run(n % 3, r, 2, 0);
        end
        foreach (wid[i]) begin
            run(i, 9, 2, 0);
            run(i, 10, 2, 0);
            run(i, 100, 2, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
